// File: rtl/pipeline_imem_responder.sv
// rtl/pipeline_imem_responder.sv - two-slot prefetch window serving fetch PC and PC+1
//
// Purpose:
//   Serves mem[pc] and mem[pc+1] to the fetch stage from a two-entry
//   prefetch window. The window is filled from a backing memory over a
//   req/ack port that has at most one request outstanding. While the
//   window misses, NOP_INSTR is driven and imem_stall is raised.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   pc           in   fetch PC, used combinationally
//   fetch_instr  out  mem[pc] or NOP_INSTR
//   next_instr   out  mem[pc+1] or NOP_INSTR
//   fetch_valid  out  fetch_instr holds mem[pc]
//   next_valid   out  next_instr holds mem[pc+1]
//   imem_stall   out  inverse of fetch_valid
//   mem_req      out  backing read request (registered)
//   mem_addr     out  backing read address (registered)
//   mem_ack      in   read data valid, completes the outstanding request
//   mem_rdata    in   read data, sampled only on mem_ack

module pipeline_imem_responder #(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [15:0] fetch_instr,
  output logic [15:0] next_instr,
  output logic        fetch_valid,
  output logic        next_valid,
  output logic        imem_stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL0,
    S_FILL1,
    S_FULL,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [15:0] r_tag;
  logic [15:0] r_slot0;
  logic [15:0] r_slot1;
  logic        r_v0;
  logic        r_v1;
  logic        r_mem_req;
  logic [15:0] r_mem_addr;

  logic [15:0] w_tag1;
  logic [15:0] w_tag2;
  logic        w_hit0;
  logic        w_hit1;
  logic        w_ack;
  logic        w_redirect;
  logic        w_restart;

  assign w_tag1 = r_tag + 16'd1;
  assign w_tag2 = r_tag + 16'd2;
  assign w_hit0 = (pc == r_tag) && r_v0;
  assign w_hit1 = (pc == w_tag1) && r_v1;

  // An ack only means something while a request is outstanding; a stray
  // ack after reset dropped the request is ignored.
  assign w_ack = mem_ack && r_mem_req;

  assign w_redirect = (pc != r_tag) && (pc != w_tag1);

  // Restart the window at the current pc: from IDLE, when a drain
  // completes, on a redirect in FULL (nothing outstanding), or on a
  // redirect during a fill whose request completes in the same cycle.
  always_comb begin
    w_restart = 1'b0;
    case (r_state)
      S_IDLE:  w_restart = 1'b1;
      S_DRAIN: w_restart = w_ack;
      S_FULL:  w_restart = w_redirect;
      S_FILL0,
      S_FILL1: w_restart = w_redirect && w_ack;
      default: w_restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tag      <= 16'h0000;
      r_slot0    <= 16'h0000;
      r_slot1    <= 16'h0000;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 16'h0000;
    end else if (w_restart) begin
      r_state    <= S_FILL0;
      r_tag      <= pc;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_mem_req  <= 1'b1;
      r_mem_addr <= pc;
    end else begin
      case (r_state)
        S_FILL0: begin
          if (w_redirect) begin
            // Request still in flight: its data must be discarded.
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_state <= S_DRAIN;
          end else if (w_ack) begin
            r_slot0    <= mem_rdata;
            r_v0       <= 1'b1;
            r_mem_addr <= w_tag1;
            r_state    <= S_FILL1;
          end
        end
        S_FILL1: begin
          if (w_redirect) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_state <= S_DRAIN;
          end else if (w_ack) begin
            // If pc already sits on tag+1 the shift happens next cycle
            // from FULL, never combining store and shift in one edge.
            r_slot1   <= mem_rdata;
            r_v1      <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_hit1) begin
            // Slide the window by one and prefetch the new tag+1.
            r_slot0    <= r_slot1;
            r_tag      <= w_tag1;
            r_v1       <= 1'b0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_tag2;
            r_state    <= S_FILL1;
          end
        end
        S_DRAIN: begin
          r_state <= S_DRAIN;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Output mux: only registered slot data is ever forwarded.
  always_comb begin
    fetch_instr = NOP_INSTR;
    next_instr  = NOP_INSTR;
    fetch_valid = 1'b0;
    next_valid  = 1'b0;
    if (w_hit0) begin
      fetch_instr = r_slot0;
      fetch_valid = 1'b1;
      if (r_v1) begin
        next_instr = r_slot1;
        next_valid = 1'b1;
      end
    end else if (w_hit1) begin
      fetch_instr = r_slot1;
      fetch_valid = 1'b1;
    end
  end

  assign imem_stall = !fetch_valid;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_pipeline_imem_responder.sv
// tb/tb_pipeline_imem_responder.sv - self-checking bench for pipeline_imem_responder

module tb_pipeline_imem_responder;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [15:0] fetch_instr;
  logic [15:0] next_instr;
  logic        fetch_valid;
  logic        next_valid;
  logic        imem_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;

  pipeline_imem_responder #(.NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .fetch_instr (fetch_instr),
    .next_instr  (next_instr),
    .fetch_valid (fetch_valid),
    .next_valid  (next_valid),
    .imem_stall  (imem_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          lat_fix = 1;
  int          lat = 1;
  int          wait_cnt = 0;
  bit          force_ack = 1'b0;
  bit          ack_now = 1'b0;
  bit          prev_open = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  logic [15:0] prev_pc = 16'h0000;
  int          stall_run = 0;
  int          nvalid = 0;

  // Backing memory contents.
  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0001) return 16'h5678;
    h = a * 16'h9E37;
    return h ^ 16'h3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive pc/reset after the edge, answer the memory
  // port, then check the window rules against the memory image.
  task automatic cycle(input logic [15:0] p, input logic rst);
    @(posedge clk);
    #1;
    reset = rst;
    pc    = p;
    if (prev_open) begin
      chk("req_hold", mem_req, 1);
      chk("addr_stable", mem_addr, prev_addr);
    end
    if (rst) begin
      ack_now  = force_ack;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt >= lat) begin
        ack_now  = 1'b1;
        wait_cnt = 0;
        lat      = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end else begin
        ack_now = 1'b0;
        wait_cnt++;
      end
    end else begin
      ack_now  = force_ack;
      wait_cnt = 0;
    end
    mem_ack   = ack_now;
    mem_rdata = (ack_now && mem_req) ? memf(mem_addr) : 16'($urandom);
    #2;
    chk("stall", imem_stall, !fetch_valid);
    chk("fetch", fetch_instr, fetch_valid ? memf(pc) : NOP);
    chk("next", next_instr, next_valid ? memf(pc + 16'd1) : NOP);
    if (next_valid) begin
      chk("next_implies_fetch", fetch_valid, 1);
      chk("full_no_req", mem_req, 0);
    end
    if (pc != prev_pc && pc != prev_pc + 16'd1 && pc != prev_pc - 16'd1)
      chk("jump_latency", fetch_valid, 0);
    if (fetch_valid) nvalid++;
    if (imem_stall && pc == prev_pc) stall_run++;
    else stall_run = 0;
    chk("progress", stall_run > 40, 0);
    prev_pc   = pc;
    prev_open = mem_req && !ack_now && !rst;
    prev_addr = mem_addr;
  endtask

  task automatic wait_full(input logic [15:0] p, input string tag);
    int n;
    n = 0;
    cycle(p, 1'b0);
    while (!next_valid && n < 30) begin
      cycle(p, 1'b0);
      n++;
    end
    chk(tag, next_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;
    logic [15:0] p;

    // Reset state
    cycle(16'h0000, 1'b1);
    cycle(16'h0000, 1'b1);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_next_valid", next_valid, 0);
    chk("rst_stall", imem_stall, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_fetch_nop", fetch_instr, NOP);
    chk("rst_next_nop", next_instr, NOP);

    // 1: first fill from pc 0, ack latency 1
    lat_fix = 1;
    lat = 1;
    cycle(16'h0000, 1'b0);
    cycle(16'h0000, 1'b0);
    chk("t1_req", mem_req, 1);
    chk("t1_addr0", mem_addr, 16'h0000);
    n = 0;
    while (!(mem_req && mem_addr == 16'h0001) && n < 10) begin
      cycle(16'h0000, 1'b0);
      n++;
    end
    chk("t1_addr1", mem_addr, 16'h0001);
    wait_full(16'h0000, "t1_full");
    chk("t1_fetch", fetch_instr, 16'h1234);
    chk("t1_next", next_instr, 16'h5678);

    // 2: straight-line 0..7, pc advances only when not stalled
    n = 0;
    while (!(pc == 16'd7 && fetch_valid) && n < 80) begin
      cycle(imem_stall ? pc : pc + 16'd1, 1'b0);
      n++;
    end
    chk("t2_reached7", pc == 16'd7 && fetch_valid, 1);

    // 3: hold pc at 3
    wait_full(16'd3, "t3_full");
    for (int i = 0; i < 5; i++) begin
      cycle(16'd3, 1'b0);
      chk("t3_fetch", fetch_instr, memf(16'd3));
      chk("t3_next", next_instr, memf(16'd4));
      chk("t3_no_req", mem_req, 0);
    end

    // 4: jump to 40 while the request for 4 is outstanding, latency 3
    lat_fix = 3;
    lat = 3;
    wait_full(16'd2, "t4_full");
    cycle(16'd3, 1'b0);
    cycle(16'd40, 1'b0);
    chk("t4_req4", mem_req, 1);
    chk("t4_addr4", mem_addr, 16'd4);
    n = 0;
    while (!ack_now && n < 10) begin
      cycle(16'd40, 1'b0);
      n++;
    end
    chk("t4_ack_seen", ack_now, 1);
    cycle(16'd40, 1'b0);
    chk("t4_req40", mem_req, 1);
    chk("t4_addr40", mem_addr, 16'd40);
    wait_full(16'd40, "t4_full40");
    chk("t4_fetch40", fetch_instr, memf(16'd40));

    // 5: wrap at 16'hFFFF
    lat_fix = 1;
    wait_full(16'hFFFF, "t5_full");
    chk("t5_next_wrap", next_instr, 16'h1234);
    cycle(16'h0000, 1'b0);
    cycle(16'h0000, 1'b0);
    chk("t5_req", mem_req, 1);
    chk("t5_addr1", mem_addr, 16'h0001);

    // 6: reset with a request outstanding, then a stray ack
    cycle(16'h0000, 1'b1);
    force_ack = 1'b1;
    cycle(16'h0000, 1'b0);
    force_ack = 1'b0;
    chk("t6_req_dropped", mem_req, 0);
    chk("t6_fetch_valid", fetch_valid, 0);
    chk("t6_stall", imem_stall, 1);
    chk("t6_fetch_nop", fetch_instr, NOP);
    chk("t6_next_nop", next_instr, NOP);
    cycle(16'h0000, 1'b0);
    chk("t6_refill_req", mem_req, 1);
    chk("t6_refill_addr", mem_addr, 16'h0000);
    chk("t6_no_pollute", fetch_valid, 0);

    // Randomized core-like fetch with jumps and random ack latency
    lat_fix = -1;
    nvalid = 0;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) p = 16'($urandom);
      else if (r < 5) p = 16'hFFFD + 16'($urandom_range(0, 3));
      else if (r < 7) p = pc - 16'd1;
      else if (!imem_stall && r < 85) p = pc + 16'd1;
      else p = pc;
      cycle(p, 1'b0);
    end
    chk("rand_progress", nvalid > 300, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
